// File: rtl/deaggregator.sv
// deaggregator: unpacks one FETCH_WIDTH*DATA_WIDTH wide word into FETCH_WIDTH narrow words, lane 0 first.
// Latency: the first narrow word appears the cycle after the wide word is dequeued. Sustained rate is one word per cycle.
// Backpressure: receiver_full_n low freezes the held word and lane index. Upstream is popped only when the
//   register is empty, or when its last lane leaves in the same cycle.
//
// Ports:
//   clk, rst_n       sole clock; asynchronous active-low reset
//   sender_data      wide word from the upstream FIFO (lane i = bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH])
//   sender_empty_n   upstream word valid
//   sender_deq       pops the upstream FIFO at the rising edge
//   receiver_data    narrow word currently presented (held lane[index])
//   receiver_full_n  downstream FIFO can accept a word
//   receiver_enq     pushes receiver_data downstream at the rising edge
//   receiver_last    (only with DEAGGREGATOR_LAST_EN defined) high while the last lane is presented
//
// Build option: define DEAGGREGATOR_LAST_EN to add the receiver_last output.
module deaggregator #(
   parameter int DATA_WIDTH  = 16,
   parameter int FETCH_WIDTH = 4
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data,
   input  logic                              sender_empty_n,
   output logic                              sender_deq,
   output logic [DATA_WIDTH-1:0]             receiver_data,
   input  logic                              receiver_full_n,
   output logic                              receiver_enq
`ifdef DEAGGREGATOR_LAST_EN
   ,
   output logic                              receiver_last
`endif
);

   localparam int               WIDE_W   = FETCH_WIDTH * DATA_WIDTH;
   localparam int               IDX_W    = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FETCH_WIDTH - 1);

   typedef enum logic {
      EMPTY = 1'b0,   // no wide word held
      DRAIN = 1'b1    // wide word held; lanes index..FETCH_WIDTH-1 still to send
   } state_t;

   state_t              state, state_nxt;
   logic [IDX_W-1:0]    index, index_nxt;
   logic [WIDE_W-1:0]   held,  held_nxt;

   logic                valid;
   logic                at_last;
   logic                load;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EMPTY;
         index <= '0;
         held  <= '0;
      end else begin
         state <= state_nxt;
         index <= index_nxt;
         held  <= held_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next state and handshake outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt    = state;
      index_nxt    = index;
      held_nxt     = held;

      valid        = (state == DRAIN);
      at_last      = (index == LAST_IDX);
      receiver_enq = valid & receiver_full_n;

      // Refill when empty, or when the last lane leaves this cycle. The refill
      // overlaps the final lane, so consecutive wide words drain without a bubble.
      load         = sender_empty_n & (~valid | (receiver_enq & at_last));

      // The flops are held in reset anyway. Only the visible pop must be
      // suppressed while rst_n is low, so an upstream word is not lost.
      sender_deq   = load & rst_n;

      unique case (state)
         EMPTY: begin
            if (load) begin
               state_nxt = DRAIN;
               index_nxt = '0;
               held_nxt  = sender_data;
            end
         end
         DRAIN: begin
            if (load) begin
               state_nxt = DRAIN;
               index_nxt = '0;
               held_nxt  = sender_data;
            end else if (receiver_enq) begin
               if (at_last) begin
                  state_nxt = EMPTY;
                  index_nxt = '0;
               end else begin
                  index_nxt = index + 1'b1;
               end
            end
         end
         default: begin
            state_nxt = EMPTY;
            index_nxt = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Lane select
   // ------------------------------------------------------------------
   // An explicit compare-mux keeps unreachable index codes (non power-of-two
   // FETCH_WIDTH) well defined. Those codes read as zero.
   always_comb begin
      receiver_data = '0;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         if (index == IDX_W'(i)) begin
            receiver_data = held[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

`ifdef DEAGGREGATOR_LAST_EN
   assign receiver_last = valid & at_last;
`endif

endmodule

// File: doc/deaggregator.md
DEAGGREGATOR -- requirements
Module: deaggregator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of one narrow output word.
REQ-002 SHALL have parameter FETCH_WIDTH, default 4, narrow words per wide input word (legal 1..16).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port sender_data  input  FETCH_WIDTH*DATA_WIDTH  wide word from upstream FIFO; lane i = bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
REQ-006 SHALL have port sender_empty_n  input  1  high when sender_data is valid.
REQ-007 SHALL have port sender_deq  output  1  pops the upstream FIFO at the rising edge when high.
REQ-008 SHALL have port receiver_data  output  DATA_WIDTH  current narrow word.
REQ-009 SHALL have port receiver_full_n  input  1  high when downstream FIFO accepts a word.
REQ-010 SHALL have port receiver_enq  output  1  pushes receiver_data downstream at the rising edge when high.

Function
REQ-011 SHALL be the wide-to-narrow counterpart of the packing stage: it unpacks FETCH_WIDTH*DATA_WIDTH words into DATA_WIDTH words for a narrow FIFO.
REQ-012 SHALL hold one wide word in an internal register plus a lane index counter of max(1,$clog2(FETCH_WIDTH)) bits and a valid flag.
REQ-013 SHALL have two states: EMPTY (valid=0) and DRAIN (valid=1).
REQ-014 SHALL emit lanes in ascending order, lane 0 first, so that word order matches the packing order upstream.
REQ-015 SHALL drive receiver_data = held lane[index] combinationally.
REQ-016 SHALL drive receiver_enq = valid AND receiver_full_n, combinationally.
REQ-017 SHALL drive sender_deq = sender_empty_n AND (NOT valid OR (receiver_enq AND index==FETCH_WIDTH-1)).
REQ-018 On sender_deq: register <= sender_data, index <= 0, valid <= 1 (EMPTY->DRAIN or DRAIN->DRAIN).
REQ-019 On receiver_enq with index < FETCH_WIDTH-1: index increments by 1; register unchanged.
REQ-020 On receiver_enq with index == FETCH_WIDTH-1 and no sender_deq: valid <= 0, index <= 0 (DRAIN->EMPTY).
REQ-021 Stall: receiver_full_n low holds register, index and valid; no word lost or repeated.
REQ-022 Latency: first narrow word presented the cycle after the wide word is dequeued.
REQ-023 Throughput: with sender never empty and receiver never full, SHALL enqueue one narrow word every cycle, no bubble between wide words.
REQ-024 FETCH_WIDTH==1: every enqueue is a last-lane enqueue; block degenerates to a one-entry pipeline register.

Reset
REQ-025 While rst_n low: valid=0, index=0, held register=0; hence receiver_enq=0, sender_deq=0, receiver_data=0.
REQ-026 Reset asserted mid-word SHALL discard remaining lanes immediately; after release block is in EMPTY.
REQ-027 First sender_deq after release SHALL occur in the first cycle with rst_n high and sender_empty_n high.

Configuration
REQ-028 Macro DEAGGREGATOR_LAST_EN SHALL gate an extra output port receiver_last  output  1.
REQ-029 With DEAGGREGATOR_LAST_EN defined: receiver_last = valid AND index==FETCH_WIDTH-1; 0 in reset.
REQ-030 Without DEAGGREGATOR_LAST_EN: port absent; all other behaviour identical.

Verification
REQ-031 Defaults, upstream FIFO preloaded with wide words {3,2,1,0},{7,6,5,4} (lane3..lane0), receiver always ready -> receiver_data 0,1,2,...,7 on 8 consecutive cycles; sender_deq pulses on the cycle before the first word and on the cycle word 3 enqueues.
REQ-032 Random 50% receiver_full_n stall over 64 wide words of incrementing lanes -> narrow stream strictly 0,1,2,...,255; no gaps, no duplicates; receiver_enq never high when receiver_full_n low.
REQ-033 Sender empty after one wide word -> after 4 enqueues state EMPTY, receiver_enq 0, sender_deq 0 until sender_empty_n rises.
REQ-034 rst_n pulled low after 2 of 4 lanes enqueued -> receiver_enq drops asynchronously; after release, next output is lane 0 of the next wide word.
REQ-035 DEAGGREGATOR_LAST_EN defined, FETCH_WIDTH=4 -> receiver_last high exactly on every 4th enqueue (words 3,7,11,...).
REQ-036 FETCH_WIDTH=1, DATA_WIDTH=8, inputs 0..9 back-to-back -> outputs 0..9 one per cycle, latency 1.
